// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between IF (id 0) and LSU (id 1); MEM_PORT_ARB_RR_EN selects round-robin over LSU-first priority.
module mem_port_arbiter #(
    parameter int MAX_OUTSTANDING = 2,
    parameter int N_BITS = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_val,
    output logic              if_req_rdy,
    input  logic [N_BITS-1:0] if_req_addr,
    input  logic              lsu_req_val,
    output logic              lsu_req_rdy,
    input  logic [N_BITS-1:0] lsu_req_addr,
    input  logic              lsu_req_wen,
    input  logic [N_BITS-1:0] lsu_req_wdata,
    input  logic [3:0]        lsu_req_wstrb,
    output logic              if_resp_val,
    output logic [N_BITS-1:0] if_resp_rdata,
    output logic              lsu_resp_val,
    output logic [N_BITS-1:0] lsu_resp_rdata,
    output logic              mem_req_val,
    input  logic              mem_req_rdy,
    output logic [N_BITS-1:0] mem_req_addr,
    output logic              mem_req_wen,
    output logic [N_BITS-1:0] mem_req_wdata,
    output logic [3:0]        mem_req_wstrb,
    input  logic              mem_resp_val,
    input  logic [N_BITS-1:0] mem_resp_rdata,
    output logic              err_unexpected_resp
);
    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CW = $clog2(MAX_OUTSTANDING) + 1;

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t                     state;
    logic                       lock_id;
    logic [MAX_OUTSTANDING-1:0] ids;
    logic [PW-1:0]              wr_ptr, rd_ptr;
    logic [CW-1:0]              count;
    logic                       win, sel, full, empty, accept, pop, head;

`ifdef MEM_PORT_ARB_RR_EN
    logic rr_ptr;
    assign win = (if_req_val && lsu_req_val) ? rr_ptr : lsu_req_val;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rr_ptr <= 1'b0;
        else if (accept)
            rr_ptr <= ~rr_ptr;
    end
`else
    assign win = lsu_req_val;
`endif

    assign sel         = (state == LOCKED) ? lock_id : win;
    assign full        = count == CW'(MAX_OUTSTANDING);
    assign empty       = count == '0;
    // rst gates the request side so nothing leaks out while reset is held
    assign mem_req_val = !rst && (if_req_val || lsu_req_val || state == LOCKED) && !full;
    assign accept      = mem_req_val && mem_req_rdy;
    assign if_req_rdy  = accept && !sel;
    assign lsu_req_rdy = accept && sel;

    assign mem_req_addr  = sel ? lsu_req_addr : if_req_addr;
    assign mem_req_wen   = sel && lsu_req_wen;
    assign mem_req_wdata = lsu_req_wdata;
    assign mem_req_wstrb = sel ? lsu_req_wstrb : 4'h0;

    assign head           = ids[rd_ptr];
    assign pop            = mem_resp_val && !empty;
    assign if_resp_val    = pop && !head;
    assign lsu_resp_val   = pop && head;
    assign if_resp_rdata  = mem_resp_rdata;
    assign lsu_resp_rdata = mem_resp_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            lock_id <= 1'b0;
        end else if (state == IDLE && mem_req_val && !mem_req_rdy) begin
            state   <= LOCKED;
            lock_id <= sel;
        end else if (state == LOCKED && mem_req_rdy) begin
            state   <= IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ids    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            err_unexpected_resp <= 1'b0;
        end else begin
            if (accept) begin
                ids[wr_ptr] <= sel;
                wr_ptr      <= (wr_ptr == PW'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= (rd_ptr == PW'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr + 1'b1;
            count <= count + CW'(accept) - CW'(pop);
            if (mem_resp_val && empty)
                err_unexpected_resp <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and random checks of mem_port_arbiter against a queue-based reference model.
module tb_mem_port_arbiter;
    localparam int MAXO = 2;

    logic        clk = 1'b0, rst;
    logic        if_req_val, if_req_rdy, lsu_req_val, lsu_req_rdy, lsu_req_wen;
    logic [31:0] if_req_addr, lsu_req_addr, lsu_req_wdata;
    logic [3:0]  lsu_req_wstrb, mem_req_wstrb;
    logic        if_resp_val, lsu_resp_val, mem_req_val, mem_req_rdy, mem_req_wen;
    logic [31:0] if_resp_rdata, lsu_resp_rdata, mem_req_addr, mem_req_wdata;
    logic        mem_resp_val, err_unexpected_resp;
    logic [31:0] mem_resp_rdata;

    always #5 clk = ~clk;

    mem_port_arbiter #(.MAX_OUTSTANDING(MAXO)) dut (
        .clk(clk), .rst(rst),
        .if_req_val(if_req_val), .if_req_rdy(if_req_rdy), .if_req_addr(if_req_addr),
        .lsu_req_val(lsu_req_val), .lsu_req_rdy(lsu_req_rdy), .lsu_req_addr(lsu_req_addr),
        .lsu_req_wen(lsu_req_wen), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wstrb(lsu_req_wstrb),
        .if_resp_val(if_resp_val), .if_resp_rdata(if_resp_rdata),
        .lsu_resp_val(lsu_resp_val), .lsu_resp_rdata(lsu_resp_rdata),
        .mem_req_val(mem_req_val), .mem_req_rdy(mem_req_rdy), .mem_req_addr(mem_req_addr),
        .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
        .mem_resp_val(mem_resp_val), .mem_resp_rdata(mem_resp_rdata),
        .err_unexpected_resp(err_unexpected_resp)
    );

    int n_tests = 0, n_fail = 0;
    int q[$];
    bit locked, lid, rr, err_m, full, e_val, e_ifr, e_lsr, e_pop, win, head;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit iv, input logic [31:0] ia, input bit lv, input logic [31:0] la,
                         input bit lw, input logic [31:0] wd, input logic [3:0] ws,
                         input bit mr, input bit rv, input logic [31:0] rd);
        if_req_val = iv; if_req_addr = ia;
        lsu_req_val = lv; lsu_req_addr = la; lsu_req_wen = lw; lsu_req_wdata = wd; lsu_req_wstrb = ws;
        mem_req_rdy = mr; mem_resp_val = rv; mem_resp_rdata = rd;
        #1;
    endtask

    // Expected outputs for the current inputs, derived from the arbitration rules.
    task automatic predict();
        if (rst) begin
            q.delete(); locked = 0; lid = 0; rr = 0; err_m = 0;
        end
        full  = q.size() >= MAXO;
        e_val = !rst && (if_req_val || lsu_req_val || locked) && !full;
`ifdef MEM_PORT_ARB_RR_EN
        win = locked ? lid : (if_req_val && lsu_req_val) ? rr : lsu_req_val;
`else
        win = locked ? lid : lsu_req_val;
`endif
        e_ifr = e_val && mem_req_rdy && !win;
        e_lsr = e_val && mem_req_rdy && win;
        e_pop = mem_resp_val && q.size() > 0;
        head  = (q.size() > 0) ? q[0][0] : 1'b0;
    endtask

    task automatic step();
        #1;
        predict();
        check("mem_req_val", mem_req_val, e_val);
        check("if_req_rdy", if_req_rdy, e_ifr);
        check("lsu_req_rdy", lsu_req_rdy, e_lsr);
        if (e_val) begin
            check("mem_req_addr", mem_req_addr, win ? lsu_req_addr : if_req_addr);
            check("mem_req_wen", mem_req_wen, win && lsu_req_wen);
            check("mem_req_wstrb", mem_req_wstrb, win ? lsu_req_wstrb : 4'h0);
            if (win) check("mem_req_wdata", mem_req_wdata, lsu_req_wdata);
        end
        check("if_resp_val", if_resp_val, e_pop && !head);
        check("lsu_resp_val", lsu_resp_val, e_pop && head);
        if (mem_resp_val) begin
            check("if_resp_rdata", if_resp_rdata, mem_resp_rdata);
            check("lsu_resp_rdata", lsu_resp_rdata, mem_resp_rdata);
        end
        check("err_unexpected_resp", err_unexpected_resp, err_m);
        @(posedge clk);
        if (!rst) begin
            if (mem_resp_val) begin
                if (q.size() == 0) err_m = 1;
                else void'(q.pop_front());
            end
            if (e_ifr || e_lsr) begin
                q.push_back(int'(win));
                rr = !rr;
            end
            if (!locked && e_val && !mem_req_rdy) begin
                locked = 1; lid = win;
            end else if (locked && mem_req_rdy) begin
                locked = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 8 && q.size() > 0; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0, 1, $urandom);
            step();
        end
        check("drain_empty", q.size(), 0);
    endtask

    initial begin
        rst = 1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        // reset holds the port quiet even with a live request
        drive(1, 32'h40, 0, 0, 0, 0, 0, 1, 0, 0);
        check("rst_mem_req_val", mem_req_val, 0);
        check("rst_if_req_rdy", if_req_rdy, 0);
        step();
        rst = 0;
        drive(1, 32'h40, 0, 0, 0, 0, 0, 1, 0, 0);
        check("post_rst_if_rdy", if_req_rdy, 1);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 32'hAAAA5555);
        check("post_rst_if_resp", if_resp_val, 1);
        step();
        // conflict: LSU first, then IF
        drive(1, 32'h100, 1, 32'h2000, 1, 32'hDEADBEEF, 4'hF, 1, 0, 0);
        check("conf_lsu_rdy", lsu_req_rdy, 1);
        check("conf_if_rdy", if_req_rdy, 0);
        check("conf_wen", mem_req_wen, 1);
        check("conf_addr", mem_req_addr, 32'h2000);
        check("conf_wdata", mem_req_wdata, 32'hDEADBEEF);
        step();
        drive(1, 32'h100, 0, 0, 0, 0, 0, 1, 0, 0);
        check("conf_if_next", if_req_rdy, 1);
        check("conf_if_wstrb", mem_req_wstrb, 4'h0);
        step();
        // FIFO full: nothing accepted, even with a same-cycle response
        drive(1, 32'h300, 1, 32'h304, 0, 0, 4'h0, 1, 0, 0);
        check("full_val", mem_req_val, 0);
        check("full_rdy", if_req_rdy | lsu_req_rdy, 0);
        step();
        drive(1, 32'h300, 1, 32'h304, 0, 0, 4'h0, 1, 1, 32'h22222222);
        check("full_pop_val", mem_req_val, 0);
        check("full_pop_lsu_resp", lsu_resp_val, 1);
        step();
        drive(1, 32'h300, 1, 32'h304, 0, 0, 4'h0, 1, 0, 0);
        check("after_full_lsu_rdy", lsu_req_rdy, 1);
        step();
        // in-order routing: IF response then LSU response
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h11111111);
        check("route_if", if_resp_val, 1);
        check("route_if_data", if_resp_rdata, 32'h11111111);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h22222222);
        check("route_lsu", lsu_resp_val, 1);
        check("route_lsu_data", lsu_resp_rdata, 32'h22222222);
        step();
        // grant lock: LSU stalled, IF arrives, address must not switch
        drive(0, 0, 1, 32'h500, 0, 0, 4'h0, 0, 0, 0);
        check("lock_addr0", mem_req_addr, 32'h500);
        step();
        for (int i = 0; i < 2; i++) begin
            drive(1, 32'h600, 1, 32'h500, 0, 0, 4'h0, 0, 0, 0);
            check("lock_addr", mem_req_addr, 32'h500);
            step();
        end
        drive(1, 32'h600, 1, 32'h500, 0, 0, 4'h0, 1, 0, 0);
        check("lock_release_lsu", lsu_req_rdy, 1);
        check("lock_release_if", if_req_rdy, 0);
        step();
        drive(1, 32'h600, 0, 0, 0, 0, 4'h0, 1, 0, 0);
        check("lock_then_if", if_req_rdy, 1);
        step();
        drain();
        // random traffic with held requests
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 1500; i++) begin
            if (!if_req_val || e_ifr) begin
                if_req_val  = 1'($urandom_range(0, 1));
                if_req_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (!lsu_req_val || e_lsr) begin
                lsu_req_val   = 1'($urandom_range(0, 1));
                lsu_req_addr  = $urandom;
                lsu_req_wen   = 1'($urandom_range(0, 1));
                lsu_req_wdata = $urandom;
                lsu_req_wstrb = 4'($urandom);
            end
            mem_req_rdy    = $urandom_range(0, 3) != 0;
            mem_resp_val   = q.size() > 0 && $urandom_range(0, 2) == 0;
            mem_resp_rdata = $urandom;
            step();
        end
        drain();
        // response with nothing outstanding
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h33333333);
        check("unexp_if_resp", if_resp_val, 0);
        check("unexp_lsu_resp", lsu_resp_val, 0);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("unexp_err_set", err_unexpected_resp, 1);
        step();
        step();
        rst = 1;
        step();
        rst = 0;
        check("err_cleared", err_unexpected_resp, 0);
        step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
